// File: rtl/calc_display_ctrl.sv
// Digit capture, atomic commit and 8-digit 7-segment scan for the calculator.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros on commit.
module calc_display_ctrl #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] seg,
  output logic [7:0] an,
  output logic [2:0] idx
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [7:0] OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  localparam logic [1:0] ST_ERRO  = 2'b00;
  localparam logic [1:0] ST_PRONT = 2'b10;
  localparam logic [1:0] ST_IMPR  = 2'b11;

  logic [3:0]    shadow     [8];
  logic [3:0]    visible    [8];
  logic [3:0]    shadow_nxt [8];
  logic [3:0]    commit_val [8];
  logic [1:0]    status_q;
  logic          err;
  logic [CW-1:0] cnt;
  logic          wr;
  logic          commit;
  logic [3:0]    slot;
  logic [6:0]    glyph;
  logic [7:0]    an_h;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h00;
    endcase
  endfunction

  assign slot   = pos - 4'd1;
  assign wr     = (status == ST_IMPR) && (pos != 4'd0) && (pos <= 4'd8);
  assign commit = (status_q == ST_IMPR) && (status == ST_PRONT);

  always_comb begin
    for (int i = 0; i < 8; i++) shadow_nxt[i] = shadow[i];
    if (wr) shadow_nxt[slot[2:0]] = data;
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (shadow_nxt[i] != 4'd0) seen = 1'b1;
      commit_val[i] = seen ? shadow_nxt[i] : 4'hF;
    end
    commit_val[0] = shadow_nxt[0];
  end
`else
  always_comb begin
    for (int i = 0; i < 8; i++) commit_val[i] = shadow_nxt[i];
  end
`endif

  // Error glyphs run E,r,r,o from digit 0 upward.
  always_comb begin
    glyph = 7'h00;
    an_h  = 8'b1 << idx;
    unique case (1'b1)
      err: begin
        case (idx)
          3'd0:    glyph = 7'h79;
          3'd1:    glyph = 7'h50;
          3'd2:    glyph = 7'h50;
          3'd3:    glyph = 7'h5C;
          default: glyph = 7'h00;
        endcase
      end
      default: glyph = dec(visible[idx]);
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i]  <= 4'hF;
        visible[i] <= 4'hF;
      end
      status_q <= ST_PRONT;
      err      <= 1'b0;
      cnt      <= '0;
      idx      <= 3'd0;
      seg      <= OFF;
      an       <= OFF;
    end else begin
      for (int i = 0; i < 8; i++) shadow[i] <= shadow_nxt[i];
      if (commit)
        for (int i = 0; i < 8; i++) visible[i] <= commit_val[i];
      status_q <= status;
      err      <= (status == ST_ERRO);
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg <= SEG_ACTIVE_LOW ? ~{1'b0, glyph} : {1'b0, glyph};
      an  <= SEG_ACTIVE_LOW ? ~an_h : an_h;
    end
  end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Directed bench for calc_display_ctrl (REFRESH_DIV=4, active-low outputs).
// Expectations adapt when LEADING_ZERO_BLANK_EN is defined.
module tb_calc_display_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] seg;
  logic [7:0] an;
  logic [2:0] idx;

  int checks = 0;
  int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] ZHI = 8'hFF;
`else
  localparam logic [7:0] ZHI = 8'hC0;
`endif

  calc_display_ctrl #(
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .status(status),
    .data(data),
    .pos(pos),
    .seg(seg),
    .an(an),
    .idx(idx)
  );

  always #5 clock = ~clock;

  task automatic put(input logic [1:0] st, input logic [3:0] p,
                     input logic [3:0] d);
    status = st;
    pos    = p;
    data   = d;
    @(negedge clock);
  endtask

  task automatic seek(input int d, output bit found);
    logic [7:0] want;
    want  = ~(8'b1 << d);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (an === want) found = 1'b1;
      else @(negedge clock);
    end
  endtask

  task automatic scan_all(input string name, input logic [7:0] exp [8]);
    bit f;
    for (int d = 0; d < 8; d++) begin
      seek(d, f);
      checks++;
      if (!f || seg !== exp[d]) begin
        failures++;
        $display("FAIL %s digit%0d found=%0d seg=%h required=%h",
                 name, d, f, seg, exp[d]);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] blank [8];
    for (int i = 0; i < 8; i++) blank[i] = 8'hFF;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 8'hFF || idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_async an=%h seg=%h idx=%0d required FF FF 0",
               an, seg, idx);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (an !== 8'hFF) begin
      failures++;
      $display("FAIL reset_hold an=%h required FF", an);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (an !== 8'hFE || seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset_first an=%h seg=%h required FE FF", an, seg);
    end
    scan_all("reset_blank", blank);
  endtask

  task automatic test_capture_commit();
    logic [7:0] exp [8];
    logic [3:0] v [8];
    v = '{4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int p = 1; p <= 8; p++) put(2'b11, 4'(p), v[p-1]);
    put(2'b10, 4'd0, 4'd0);
    repeat (2) @(negedge clock);
    exp[0] = 8'hA4;
    exp[1] = 8'h99;
    for (int i = 2; i < 8; i++) exp[i] = ZHI;
    scan_all("commit_42", exp);
  endtask

  task automatic test_no_commit();
    logic [7:0] old [8];
    logic [7:0] exp [8];
    old[0] = 8'hA4;
    old[1] = 8'h99;
    for (int i = 2; i < 8; i++) old[i] = ZHI;
    put(2'b11, 4'd1, 4'd7);
    put(2'b11, 4'd2, 4'd3);
    put(2'b11, 4'd3, 4'd9);
    status = 2'b11;
    pos    = 4'd0;
    repeat (2) @(negedge clock);
    scan_all("burst_hold", old);
    put(2'b10, 4'd0, 4'd0);
    repeat (2) @(negedge clock);
    exp[0] = 8'hF8;
    exp[1] = 8'hB0;
    exp[2] = 8'h90;
    for (int i = 3; i < 8; i++) exp[i] = ZHI;
    scan_all("late_commit", exp);
  endtask

  task automatic test_error();
    logic [7:0] exp [8];
    logic [7:0] back [8];
    put(2'b00, 4'd0, 4'd0);
    repeat (3) @(negedge clock);
    exp = '{8'h86, 8'hAF, 8'hAF, 8'hA3, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    scan_all("erro", exp);
    put(2'b10, 4'd0, 4'd0);
    repeat (3) @(negedge clock);
    back[0] = 8'hF8;
    back[1] = 8'hB0;
    back[2] = 8'h90;
    for (int i = 3; i < 8; i++) back[i] = ZHI;
    scan_all("erro_clear", back);
  endtask

  task automatic test_scan_timing();
    bit f7;
    bit f0;
    logic [7:0] want;
    logic [7:0] exp [8];
    seek(7, f7);
    seek(0, f0);
    checks++;
    if (!f7 || !f0) begin
      failures++;
      $display("FAIL scan_sync found7=%0d found0=%0d required 1 1", f7, f0);
    end
    for (int s = 0; s < 9; s++) begin
      want = ~(8'b1 << (s % 8));
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (an !== want) begin
          failures++;
          $display("FAIL scan_step s=%0d k=%0d an=%h required=%h",
                   s, k, an, want);
        end
        @(negedge clock);
      end
    end
    put(2'b11, 4'd9, 4'd5);
    put(2'b11, 4'd0, 4'd5);
    put(2'b11, 4'd15, 4'd5);
    put(2'b10, 4'd0, 4'd0);
    repeat (2) @(negedge clock);
    exp[0] = 8'hF8;
    exp[1] = 8'hB0;
    exp[2] = 8'h90;
    for (int i = 3; i < 8; i++) exp[i] = ZHI;
    scan_all("bad_pos", exp);
  endtask

  task automatic test_zero();
    logic [7:0] exp [8];
    for (int p = 1; p <= 8; p++) put(2'b11, 4'(p), 4'd0);
    put(2'b10, 4'd0, 4'd0);
    repeat (2) @(negedge clock);
    exp[0] = 8'hC0;
    for (int i = 1; i < 8; i++) exp[i] = ZHI;
    scan_all("all_zero", exp);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_capture_commit();
    test_no_commit();
    test_error();
    test_scan_timing();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
